vme_local_regs: RTL

- FPGA-side slave of the CPLD local strobe bus. Consumes FRS/FWS/FA[4:0] on FSYSCLK, decodes 32 longword slots and executes the D32 read/write against a register bank.
- Returns FDTACK (active low) to the CPLD, which forwards it unchanged as VME DTACK.
- Provides control registers, status readback, firmware version, command pulses and an access counter to user logic.

---
 rtl/vme_local_regs.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/vme_local_regs.sv
// Purpose: FPGA-side slave of the CPLD local strobe bus: D32 register bank with status, version, command pulses and access counter.
// Latency: inputs registered once; write commit / read data at E1, FDTACK low after E(1+DTACK_DELAY), released one edge after the registered strobe falls.
// Backpressure: none; the CPLD master holds the strobe until FDTACK, and an early strobe release aborts the cycle without an ack.
module vme_local_regs #(
    parameter logic [31:0] FW_VERSION  = 32'h0000_0103,
    parameter int          DTACK_DELAY = 2
) (
    input  logic         FSYSCLK,
    input  logic         RST,
    input  logic         FRS,
    input  logic         FWS,
    input  logic [4:0]   FA,
    input  logic [31:0]  VD_IN,
    output logic [31:0]  VD_OUT,
    output logic         VD_OE,
    output logic         FDTACK,
    input  logic [255:0] STATUS_IN,
    output logic [511:0] REG_OUT,
    output logic [31:0]  CMD_PULSE
);

    localparam logic [3:0] DLY = 4'(DTACK_DELAY);

    typedef enum logic [1:0] {IDLE, XFER, DELAY, ACK} state_t;

    state_t            state;
    logic              frs_q, frs_p, fws_q, fws_p;
    logic [4:0]        fa_q;
    logic [31:0]       vd_q;
    logic              is_rd;
    logic [3:0]        cnt;
    logic [15:0][31:0] ctrl_q;
    logic [31:0]       scratch_q;
    logic [31:0]       acc_cnt;
    logic [7:0][31:0]  status_w;
    logic [31:0]       rd_dat;
    logic              act_stb;
    logic              wr_start, rd_start;

    assign status_w = STATUS_IN;
    assign REG_OUT  = ctrl_q;

    // Strobe of the access in flight; the other strobe is ignored once a cycle has started.
    assign act_stb  = is_rd ? frs_q : fws_q;
    // A start needs a fresh registered rising edge and the opposite strobe low.
    assign wr_start = fws_q & ~fws_p & ~frs_q;
    assign rd_start = frs_q & ~frs_p & ~fws_q;

    // Read data decode from the registered slot address; status words pass through live and are captured at E1.
    always_comb begin
        rd_dat = '0;
        if (!fa_q[4]) begin
            rd_dat = ctrl_q[fa_q[3:0]];
        end else if (fa_q[3] == 1'b0) begin
            rd_dat = status_w[fa_q[2:0]];
        end else begin
            case (fa_q)
                5'd24:   rd_dat = scratch_q;
                5'd25:   rd_dat = FW_VERSION;
                5'd27:   rd_dat = acc_cnt;
                default: rd_dat = '0;
            endcase
        end
    end

    // Input stage, access state machine, register bank and registered bus outputs.
    always_ff @(posedge FSYSCLK) begin
        if (RST) begin
            state     <= IDLE;
            frs_q     <= 1'b0;
            frs_p     <= 1'b0;
            fws_q     <= 1'b0;
            fws_p     <= 1'b0;
            fa_q      <= '0;
            vd_q      <= '0;
            is_rd     <= 1'b0;
            cnt       <= '0;
            ctrl_q    <= '0;
            scratch_q <= '0;
            acc_cnt   <= '0;
            VD_OUT    <= '0;
            VD_OE     <= 1'b0;
            FDTACK    <= 1'b1;
            CMD_PULSE <= '0;
        end else begin
            frs_q     <= FRS;
            frs_p     <= frs_q;
            fws_q     <= FWS;
            fws_p     <= fws_q;
            fa_q      <= FA;
            vd_q      <= VD_IN;
            CMD_PULSE <= '0;
            case (state)
                IDLE: begin
                    if (wr_start) begin
                        is_rd <= 1'b0;
                        cnt   <= 4'd1;
                        state <= XFER;
                        if (!fa_q[4]) begin
                            ctrl_q[fa_q[3:0]] <= vd_q;
                        end else if (fa_q == 5'd24) begin
                            scratch_q <= vd_q;
                        end else if (fa_q == 5'd26) begin
                            CMD_PULSE <= vd_q;
                        end
                    end else if (rd_start) begin
                        is_rd  <= 1'b1;
                        cnt    <= 4'd1;
                        state  <= XFER;
                        VD_OUT <= rd_dat;
                        VD_OE  <= 1'b1;
                    end
                end
                XFER, DELAY: begin
                    if (!act_stb) begin
                        // Early release: no ack, no count; a committed write stays.
                        VD_OE <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == DLY) begin
                        FDTACK  <= 1'b0;
                        acc_cnt <= acc_cnt + 32'd1;
                        state   <= ACK;
                    end else begin
                        cnt   <= cnt + 4'd1;
                        state <= DELAY;
                    end
                end
                ACK: begin
                    if (!act_stb) begin
                        FDTACK <= 1'b1;
                        VD_OE  <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
